capture_sink: RTL
=================

# capture_sink

Receive-side capture block: the consuming end of a registered producer stage. It accepts words from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. It delivers the words in order to a downstream consumer. While capturing, it counts accepted words whose masked bits are all set, giving the design an AND-style pattern statistic at the sink.

## Interface
Parameters:
- WIDTH, 8: data word width in bits (1 to 64)
- DEPTH, 4: FIFO depth in words; must be a power of two and at least 2
- CNT_W, 16: width of match_cnt

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of the FIFO and match_cnt
- in_valid  input  1  producer presents in_data
- in_ready  output  1  sink can accept a word this cycle
- in_data  input  WIDTH  producer data
- out_valid  output  1  out_data holds the oldest buffered word
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  oldest buffered word
- match_mask  input  WIDTH  bits that must all be 1 for a match
- match_cnt  output  CNT_W  saturating count of matching accepted words
- level  output  log2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: occurs when in_valid && in_ready at the rising edge. in_data is written at the write pointer, which then advances modulo DEPTH.
- Pop: occurs when out_valid && out_ready at the rising edge. The read pointer advances modulo DEPTH.
- in_ready = (level != DEPTH). It is derived only from registered state, with no combinational path from out_ready.
- out_valid = (level != 0).
- out_data is the entry at the read pointer. It is stable while out_valid && !out_ready.
- Full: in_ready is 0. A pop in the same cycle does not enable a push, so there is no pass-through when full.
- Empty: out_valid is 0, out_ready is ignored, and out_data is don't-care.
- Simultaneous push and pop when 0 < level < DEPTH: both pointers advance and level is unchanged.
- Level update: level increments on push only, decrements on pop only, and is otherwise unchanged.
- Match: on a push, if (in_data & match_mask) == match_mask, match_cnt increments by 1.
  - Saturates at 2^CNT_W-1 and holds there.
  - match_mask = 0 makes every accepted word count.
  - match_mask is sampled only at push edges.
- Producer obligations: in_data must be held while in_valid && !in_ready, and in_valid must not drop before acceptance. The sink does not check either rule.
- clr takes priority over push and pop in the same cycle. On clr:
  - both pointers and level go to 0, discarding buffered words;
  - match_cnt goes to 0;
  - any push or pop presented that cycle is ignored, and the word does not count.
- Reset (rst_n low, at any time including mid-transfer) immediately clears:
  - pointers, level and match_cnt to 0;
  - out_valid to 0 and in_ready to 1.
  - FIFO storage is not reset, so out_data is undefined until the first push.

## Timing
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N. The earliest pop is at edge N+1.
- in_ready, out_valid and level update one edge after the push or pop that changes them.
- match_cnt reflects a push at edge N after edge N.
- Throughput: one push and one pop per cycle when not full and not empty.
- Reset values: in_ready=1, out_valid=0, level=0, match_cnt=0, out_data=X.
- Reset deassertion is synchronised externally. The first push is allowed at the first edge with rst_n high.

## Test plan
- Basic order: with DEPTH=4 and out_ready=0, push 0x11, 0x22, 0x33, 0x44.
  - level reaches 4 and in_ready goes 0.
  - Then out_ready=1: pops 0x11, 0x22, 0x33, 0x44 in order, then out_valid=0 and level=0.
- Full stall: with the FIFO full, hold in_valid=1 with in_data=0x55 and pop once.
  - Nothing is written on the pop edge.
  - in_ready=1 on the next cycle, 0x55 is accepted on the following edge, and level returns to 4.
- Streaming and wrap: push 0x00..0x0F with out_ready=1 continuously.
  - All 16 words come out in order.
  - level never exceeds 1, showing pointer wrap with no loss.
- Match and saturation: with CNT_W=4 and match_mask=0x81, push 0x81, 0xFF, 0x80, 0x01.
  - match_cnt=2.
  - Push 20 more copies of 0xFF and match_cnt holds at 15.
- Clear priority: with level=3 and match_cnt=3, assert clr together with a push of 0x81 (mask 0x81) and out_ready=1.
  - Next cycle level=0, out_valid=0 and match_cnt=0.
  - The word is not stored or counted.
- Async reset: with level=2, pull rst_n low between edges.
  - out_valid=0, in_ready=1, level=0 and match_cnt=0 immediately, without waiting for a clock edge.
  - After release, push 0xA5, which is popped as 0xA5.

Source files
------------

// File: rtl/capture_sink.sv
// -----------------------------------------------------------------------------
// capture_sink
//
// Receive-side capture block. Accepts words from an upstream producer over a
// valid/ready handshake and buffers them in a small FIFO. Delivers them in
// order to a downstream consumer. Counts accepted words whose masked bits are
// all set.
//
// Parameters:
//   WIDTH  data word width (1..64)
//   DEPTH  FIFO depth in words (power of two, >= 2)
//   CNT_W  width of match_cnt
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear of FIFO and match_cnt (beats push/pop)
//   in_valid    producer presents in_data
//   in_ready    sink can accept a word this cycle
//   in_data     producer data
//   out_valid   out_data holds the oldest buffered word
//   out_ready   consumer takes out_data this cycle
//   out_data    oldest buffered word
//   match_mask  bits that must all be 1 for a match
//   match_cnt   saturating count of matching accepted words
//   level       current FIFO occupancy
// -----------------------------------------------------------------------------
module capture_sink #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic [WIDTH-1:0]           match_mask,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Storage is deliberately left out of reset; only the pointers and level
    // decide what is valid.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic push;
    logic pop;
    logic is_match;

    // Both flags come straight from the registered level, so out_ready never
    // reaches in_ready combinationally: a pop while full does not free a slot
    // until the following cycle.
    assign in_ready  = (level_reg != LVL_W'(DEPTH));
    assign out_valid = (level_reg != '0);

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign is_match = ((in_data & match_mask) == match_mask);

    assign out_data  = mem[rd_ptr_reg];
    assign level     = level_reg;
    assign match_cnt = cnt_reg;

    // Data array write. A clr cycle drops the presented word.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Control state. DEPTH is a power of two, so pointer wrap is the natural
    // overflow of a PTR_W-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            cnt_reg    <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            // Saturate at all-ones.
            if (push && is_match && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule
